// File: rtl/ln4017_pkg.sv
// ln4017_pkg
//   Shared types and helpers for the ln4017 receive-side decoder.
//   - state_t      : decoder FSM states (SYNC, TRACK, FAULT)
//   - ERR_*        : err_code values
//   - onehot_idx   : index of the set bit in a 10-bit decoded vector
//   - is_onehot    : exactly one bit set in a 10-bit decoded vector
//   - carry_high   : expected q59_n level for a given digit
//   - next_digit   : decade successor (9 wraps to 0)
package ln4017_pkg;

    localparam int NUM_DIGITS = 10;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_ONEHOT = 2'b01;
    localparam logic [1:0] ERR_CARRY  = 2'b10;
    localparam logic [1:0] ERR_SKIP   = 2'b11;

    // Only meaningful when is_onehot() holds; otherwise returns the
    // highest set bit (or 0 for an all-zero vector).
    function automatic logic [3:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            n = n + {3'd0, v[i]};
        end
        return (n == 4'd1);
    endfunction

    // The 4017 carry output is high during the first half of the decade.
    function automatic logic carry_high(input logic [3:0] idx);
        return (idx <= 4'd4);
    endfunction

    function automatic logic [3:0] next_digit(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/ln4017_decode_sync.sv
// ln4017_sync
//   Width-parameterised multi-stage flop synchronizer, cleared by reset.
//   Ports:
//     clk   in  1      sampling clock
//     rst_n in  1      asynchronous active-low reset (all stages to 0)
//     d     in  WIDTH  asynchronous input vector
//     q     out WIDTH  vector after STAGES flops
module ln4017_sync #(
    parameter int WIDTH  = 11,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/ln4017_decode.sv
// ln4017_decode
//   Receive-side decoder for a 4017 decade counter: synchronizes the decoded
//   outputs and carry, recovers the BCD digit, counts completed decades,
//   flags protocol violations and stalls.
//   Ports:
//     cp0      in  1         system clock, rising edge
//     mr_n     in  1         asynchronous active-low reset
//     out_q    in  10        decoded 4017 outputs (asynchronous)
//     q59_n    in  1         4017 carry, high for digits 0-4
//     err_clr  in  1         pulse; leaves FAULT and clears err_code
//     digit    out 4         current digit 0-9
//     valid    out 1         digit is being tracked
//     decades  out DECADE_W  completed 9->0 wraps (wrapping)
//     carry    out 1         one-cycle pulse per 9->0 wrap
//     rst_seen out 1         one-cycle pulse on an inferred 4017 master reset
//     fault    out 1         high while in FAULT
//     err_code out 2         sticky fault cause
//     stall    out 1         no advance for >= TIMEOUT cycles while tracking
module ln4017_decode
    import ln4017_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DECADE_W    = 8,
    parameter int TIMEOUT     = 1000
) (
    input  logic                cp0,
    input  logic                mr_n,
    input  logic [9:0]          out_q,
    input  logic                q59_n,
    input  logic                err_clr,
    output logic [3:0]          digit,
    output logic                valid,
    output logic [DECADE_W-1:0] decades,
    output logic                carry,
    output logic                rst_seen,
    output logic                fault,
    output logic [1:0]          err_code,
    output logic                stall
);

    // Stall counter saturates at TIMEOUT, so it only needs to hold TIMEOUT.
    localparam int                CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic              STALL_EN = (TIMEOUT != 0);

    // ------------------------------------------------------------------
    // Input synchronizer and decode of the synchronized vector
    // ------------------------------------------------------------------
    logic [10:0] s;

    ln4017_sync #(
        .WIDTH  (11),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (cp0),
        .rst_n (mr_n),
        .d     ({q59_n, out_q}),
        .q     (s)
    );

    logic       s_onehot;
    logic [3:0] s_idx;
    logic       s_carry_ok;
    logic       s_legal;

    always_comb begin
        s_onehot   = is_onehot(s[9:0]);
        s_idx      = onehot_idx(s[9:0]);
        s_carry_ok = (s[10] == carry_high(s_idx));
        s_legal    = s_onehot && s_carry_ok;
    end

    // ------------------------------------------------------------------
    // FSM and datapath registers
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [3:0]          digit_q, digit_d;
    logic                valid_q, valid_d;
    logic [DECADE_W-1:0] decades_q, decades_d;
    logic                carry_q, carry_d;
    logic                rst_seen_q, rst_seen_d;
    logic                fault_q, fault_d;
    logic [1:0]          err_q, err_d;
    logic                stall_q, stall_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_ff @(posedge cp0 or negedge mr_n) begin
        if (!mr_n) begin
            state_q <= SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        digit_d    = digit_q;
        valid_d    = valid_q;
        decades_d  = decades_q;
        carry_d    = 1'b0;
        rst_seen_d = 1'b0;
        err_d      = err_q;
        cnt_d      = cnt_q;

        case (state_q)
            SYNC: begin
                valid_d = 1'b0;
                cnt_d   = '0;
                if (s_legal) begin
                    state_d = TRACK;
                    digit_d = s_idx;
                    valid_d = 1'b1;
                end
            end

            TRACK: begin
                if (!s_legal) begin
                    state_d = FAULT;
                    valid_d = 1'b0;
                    err_d   = s_onehot ? ERR_CARRY : ERR_ONEHOT;
                end else if (s_idx == digit_q) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (s_idx == next_digit(digit_q)) begin
                    digit_d = s_idx;
                    cnt_d   = '0;
                    if (digit_q == 4'd9) begin
                        decades_d = decades_q + DECADE_W'(1);
                        carry_d   = 1'b1;
                    end
                end else if (s_idx == 4'd0) begin
                    // Falling back to 0 from mid-decade (0 and 9 were already
                    // covered above) is what a 4017 master reset looks like.
                    digit_d    = 4'd0;
                    rst_seen_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    state_d = FAULT;
                    valid_d = 1'b0;
                    err_d   = ERR_SKIP;
                end
            end

            FAULT: begin
                valid_d = 1'b0;
                if (err_clr) begin
                    state_d = SYNC;
                    err_d   = ERR_NONE;
                end
            end

            default: begin
                state_d = SYNC;
                valid_d = 1'b0;
            end
        endcase

        fault_d = (state_d == FAULT);
        stall_d = STALL_EN && (state_d == TRACK) && (cnt_d == CNT_MAX);
    end

    always_ff @(posedge cp0 or negedge mr_n) begin
        if (!mr_n) begin
            digit_q    <= 4'd0;
            valid_q    <= 1'b0;
            decades_q  <= '0;
            carry_q    <= 1'b0;
            rst_seen_q <= 1'b0;
            fault_q    <= 1'b0;
            err_q      <= ERR_NONE;
            stall_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            digit_q    <= digit_d;
            valid_q    <= valid_d;
            decades_q  <= decades_d;
            carry_q    <= carry_d;
            rst_seen_q <= rst_seen_d;
            fault_q    <= fault_d;
            err_q      <= err_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
        end
    end

    assign digit    = digit_q;
    assign valid    = valid_q;
    assign decades  = decades_q;
    assign carry    = carry_q;
    assign rst_seen = rst_seen_q;
    assign fault    = fault_q;
    assign err_code = err_q;
    assign stall    = stall_q;

endmodule

// File: tb/tb_ln4017_decode.sv
// tb_ln4017_decode
//   Self-checking bench for ln4017_decode. Two instances share all inputs:
//   dut (TIMEOUT=20) and dut0 (TIMEOUT=0). A behavioural reference model
//   computes every expected output cycle by cycle.
module tb_ln4017_decode;

    localparam int STAGES = 2;
    localparam int DW     = 8;
    localparam int TO     = 20;

    logic          cp0;
    logic          mr_n;
    logic [9:0]    out_q;
    logic          q59_n;
    logic          err_clr;

    logic [3:0]    digit, digit0;
    logic          valid, valid0;
    logic [DW-1:0] decades, decades0;
    logic          carry, carry0;
    logic          rst_seen, rst_seen0;
    logic          fault, fault0;
    logic [1:0]    err_code, err_code0;
    logic          stall, stall0;

    ln4017_decode #(.SYNC_STAGES(STAGES), .DECADE_W(DW), .TIMEOUT(TO)) dut (
        .cp0(cp0), .mr_n(mr_n), .out_q(out_q), .q59_n(q59_n), .err_clr(err_clr),
        .digit(digit), .valid(valid), .decades(decades), .carry(carry),
        .rst_seen(rst_seen), .fault(fault), .err_code(err_code), .stall(stall)
    );

    ln4017_decode #(.SYNC_STAGES(STAGES), .DECADE_W(DW), .TIMEOUT(0)) dut0 (
        .cp0(cp0), .mr_n(mr_n), .out_q(out_q), .q59_n(q59_n), .err_clr(err_clr),
        .digit(digit0), .valid(valid0), .decades(decades0), .carry(carry0),
        .rst_seen(rst_seen0), .fault(fault0), .err_code(err_code0), .stall(stall0)
    );

    // ---------------- clock ----------------
    initial begin
        cp0 = 1'b0;
        forever #5 cp0 = ~cp0;
    end

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;
    int carry_seen = 0;
    int rst_seen_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // mode: 0 = acquiring, 1 = locked on a digit, 2 = faulted
    logic [10:0] pipe [STAGES];
    int          m_mode;
    int          m_digit;
    bit          m_valid;
    int          m_decades;
    bit          m_carry;
    bit          m_rst;
    int          m_err;
    int          m_idle;

    task automatic model_reset();
        for (int i = 0; i < STAGES; i++) pipe[i] = '0;
        m_mode = 0; m_digit = 0; m_valid = 0; m_decades = 0;
        m_carry = 0; m_rst = 0; m_err = 0; m_idle = 0;
    endtask

    // Apply one rising edge of behaviour using the vector the DUT sees.
    task automatic model_edge();
        logic [10:0] sv;
        int ones, idx;
        bit cok, legal;
        if (!mr_n) begin
            model_reset();
        end else begin
            sv = pipe[STAGES-1];
            ones = $countones(sv[9:0]);
            idx = 0;
            for (int i = 0; i < 10; i++) if (sv[i]) idx = i;
            cok = (sv[10] == (idx <= 4));
            legal = (ones == 1) && cok;
            m_carry = 0;
            m_rst = 0;
            if (m_mode == 0) begin
                if (legal) begin
                    m_mode = 1; m_digit = idx; m_valid = 1; m_idle = 0;
                end else begin
                    m_valid = 0;
                end
            end else if (m_mode == 1) begin
                if (legal && idx == m_digit) begin
                    if (m_idle < 1000000) m_idle++;
                end else if (legal && idx == (m_digit + 1) % 10) begin
                    if (m_digit == 9) begin
                        m_decades = (m_decades + 1) % (1 << DW);
                        m_carry = 1;
                    end
                    m_digit = idx;
                    m_idle = 0;
                end else if (legal && idx == 0) begin
                    m_rst = 1; m_digit = 0; m_idle = 0;
                end else begin
                    m_mode = 2; m_valid = 0;
                    m_err = (ones != 1) ? 1 : (!cok ? 2 : 3);
                end
            end else begin
                if (err_clr) begin
                    m_mode = 0; m_err = 0;
                end
            end
            for (int i = STAGES - 1; i > 0; i--) pipe[i] = pipe[i-1];
            pipe[0] = {q59_n, out_q};
        end
    endtask

    task automatic compare_all();
        check("digit", digit, m_digit);
        check("valid", valid, m_valid);
        check("decades", decades, m_decades);
        check("carry", carry, m_carry);
        check("rst_seen", rst_seen, m_rst);
        check("fault", fault, (m_mode == 2));
        check("err_code", err_code, m_err);
        check("stall", stall, (m_mode == 1) && (m_idle >= TO));
        check("digit_t0", digit0, m_digit);
        check("err_code_t0", err_code0, m_err);
        check("stall_t0", stall0, 0);
        if (carry) carry_seen++;
        if (rst_seen) rst_seen_cnt++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge cp0);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int drv;  // digit currently driven onto out_q

    task automatic set_digit(input int d, input bit bad_carry = 0);
        drv = d;
        out_q = 10'd1 << d;
        q59_n = (d <= 4) ^ bad_carry;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
    endtask

    task automatic apply_reset();
        mr_n = 1'b0;
        #1;
        model_reset();
        step();
        step();
        mr_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int dec0, car0, rst0, op, nd;

    initial begin
        mr_n = 1'b0; out_q = '0; q59_n = 1'b0; err_clr = 1'b0; drv = 0;
        model_reset();
        #2;
        // Reset values while mr_n is held low.
        check("rst_digit", digit, 0);
        check("rst_valid", valid, 0);
        check("rst_decades", decades, 0);
        check("rst_fault", fault, 0);
        check("rst_err", err_code, 0);
        check("rst_stall", stall, 0);
        step();

        // Reset and acquire: digit 0 appears after three edges.
        mr_n = 1'b1;
        set_digit(0);
        run(2);
        check("acq_early_valid", valid, 0);
        step();
        check("acq_valid", valid, 1);
        check("acq_digit", digit, 0);
        check("acq_carry", carry, 0);
        check("acq_rst_seen", rst_seen, 0);

        // Counting: three full decades, 8 cycles per step.
        car0 = carry_seen;
        for (int lap = 0; lap < 3; lap++) begin
            for (int d = 1; d <= 10; d++) begin
                set_digit(d % 10);
                run(8);
            end
        end
        check("count_decades", decades, 3);
        check("count_carries", carry_seen - car0, 3);
        check("count_digit", digit, 0);

        // Inferred master reset from digit 6.
        for (int d = 1; d <= 6; d++) begin
            set_digit(d);
            run(4);
        end
        check("mr_pre_digit", digit, 6);
        dec0 = decades;
        rst0 = rst_seen_cnt;
        set_digit(0);
        run(6);
        check("mr_pulses", rst_seen_cnt - rst0, 1);
        check("mr_digit", digit, 0);
        check("mr_decades", decades, dec0);
        check("mr_fault", fault, 0);

        // Fault: not one-hot.
        out_q = 10'b0000000011; q59_n = 1'b1;
        run(4);
        check("f1_fault", fault, 1);
        check("f1_err", err_code, 1);
        pulse_clr();
        check("f1_clr_fault", fault, 0);
        check("f1_clr_err", err_code, 0);

        // Fault: carry mismatch on digit 3.
        set_digit(2);
        run(4);
        set_digit(3, 1);
        run(4);
        check("f2_fault", fault, 1);
        check("f2_err", err_code, 2);
        pulse_clr();
        check("f2_clr_err", err_code, 0);

        // Fault: skip 2 -> 4.
        set_digit(2);
        run(4);
        check("f3_valid", valid, 1);
        set_digit(4);
        run(4);
        check("f3_fault", fault, 1);
        check("f3_err", err_code, 3);
        check("f3_hold_digit", digit, 2);
        pulse_clr();
        check("f3_clr_fault", fault, 0);
        check("f3_clr_valid", valid, 0);
        run(2);

        // Stall: hold digit 4 for TIMEOUT cycles, then step to 5.
        apply_reset();
        set_digit(3);
        run(4);
        set_digit(4);
        run(3);
        check("st_digit", digit, 4);
        run(TO - 1);
        check("st_early", stall, 0);
        step();
        check("st_assert", stall, 1);
        check("st_t0", stall0, 0);
        run(5);
        set_digit(5);
        run(3);
        check("st_clear", stall, 0);
        check("st_digit5", digit, 5);

        // Randomized walk through advances, resets, jumps and faults.
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 11);
            if (op <= 6) begin
                set_digit((drv + 1) % 10);
            end else if (op == 7) begin
                set_digit(0);
            end else if (op == 8) begin
                set_digit($urandom_range(0, 9));
            end else if (op == 9) begin
                nd = $urandom_range(0, 9);
                if ($urandom_range(0, 1) == 0) begin
                    set_digit(nd, 1);
                end else begin
                    out_q = (10'd1 << nd) | (10'd1 << ((nd + 1 + $urandom_range(0, 7)) % 10));
                    drv = nd;
                end
            end else begin
                pulse_clr();
            end
            run($urandom_range(4, 26));
            if (fault && $urandom_range(0, 1) == 1) pulse_clr();
        end

        // Mid-count reset while tracking digit 7 with 5 decades.
        apply_reset();
        set_digit(0);
        run(3);
        for (int lap = 0; lap < 5; lap++) begin
            for (int d = 1; d <= 10; d++) begin
                set_digit(d % 10);
                run(4);
            end
        end
        for (int d = 1; d <= 7; d++) begin
            set_digit(d);
            run(4);
        end
        check("mc_pre_digit", digit, 7);
        check("mc_pre_decades", decades, 5);
        #2;
        mr_n = 1'b0;
        #1;
        check("mc_digit", digit, 0);
        check("mc_valid", valid, 0);
        check("mc_decades", decades, 0);
        check("mc_decades_t0", decades0, 0);
        check("mc_fault", fault, 0);
        check("mc_err", err_code, 0);
        model_reset();
        run(2);
        mr_n = 1'b1;
        car0 = carry_seen;
        rst0 = rst_seen_cnt;
        run(2);
        check("mc_early_valid", valid, 0);
        step();
        check("mc_reacq_valid", valid, 1);
        check("mc_reacq_digit", digit, 7);
        check("mc_reacq_decades", decades, 0);
        run(3);
        check("mc_no_carry", carry_seen - car0, 0);
        check("mc_no_rst", rst_seen_cnt - rst0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
